// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types and helpers for the PCIe SS TX shims.
package ofs_fim_pcie_ss_shims_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } t_merge_state;

  // A zero weight still lets the channel send one packet per turn.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/ofs_fim_pcie_ss_wrr_arb.sv
// Weighted round-robin arbiter: rr_ptr, per-turn packet quota and rotate-search.
module ofs_fim_pcie_ss_wrr_arb
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int WEIGHT_W = 4,
  parameter logic [NUM_CH*WEIGHT_W-1:0] WEIGHTS = {NUM_CH{WEIGHT_W'(1)}},
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  input  logic              last,
  input  logic              lock,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  rr_ptr
);

  localparam int CAND_W = IDX_W + 1;
  localparam logic [CAND_W-1:0] NCH = CAND_W'(NUM_CH);
  localparam logic [WEIGHT_W-1:0] QUOTA_RST = WEIGHT_W'(eff_weight(32'(WEIGHTS[WEIGHT_W-1:0])));

  logic [IDX_W-1:0]    ptr_reg;
  logic [WEIGHT_W-1:0] quota_reg;
  logic [WEIGHT_W-1:0] eff_w [NUM_CH];
  logic [CAND_W-1:0]   cand;
  logic                refill;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign eff_w[gi] = WEIGHT_W'(eff_weight(32'(WEIGHTS[gi*WEIGHT_W +: WEIGHT_W])));
      assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // The search ends on rr_ptr itself, so a lone requester refills its own quota.
  always_comb begin
    grant_idx   = ptr_reg;
    grant_valid = 1'b0;
    refill      = 1'b0;
    cand        = '0;
    if (lock) begin
      grant_valid = 1'b1;
    end else if (req[ptr_reg] && (quota_reg != '0)) begin
      grant_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = {1'b0, ptr_reg} + CAND_W'(k);
        if (cand >= NCH) cand = cand - NCH;
        if (!grant_valid && req[cand[IDX_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[IDX_W-1:0];
          refill      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      quota_reg <= QUOTA_RST;
    end else if (accept) begin
      if (refill) begin
        ptr_reg   <= grant_idx;
        quota_reg <= last ? (eff_w[grant_idx] - WEIGHT_W'(1)) : eff_w[grant_idx];
      end else if (last && (quota_reg != '0)) begin
        quota_reg <= quota_reg - WEIGHT_W'(1);
      end
    end
  end

  assign rr_ptr = ptr_reg;

endmodule

// File: rtl/ofs_fim_pcie_ss_tx_merge_nch.sv
// Packet-atomic N-channel merge of PCIe SS TX streams with weighted round-robin.
module ofs_fim_pcie_ss_tx_merge_nch
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10,
  parameter logic [NUM_CH-1:0] HDR_ONLY_MASK = '0,
  parameter int WEIGHT_W = 4,
  parameter logic [NUM_CH*WEIGHT_W-1:0] WEIGHTS = {NUM_CH{WEIGHT_W'(1)}},
  parameter int REGISTER_OUTPUT = 1,
  localparam int KEEP_W = TDATA_WIDTH / 8,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             sink_tvalid,
  output logic [NUM_CH-1:0]             sink_tready,
  input  logic [NUM_CH-1:0]             sink_tlast,
  input  logic [NUM_CH*TDATA_WIDTH-1:0] sink_tdata,
  input  logic [NUM_CH*KEEP_W-1:0]      sink_tkeep,
  input  logic [NUM_CH*TUSER_WIDTH-1:0] sink_tuser_vendor,
  output logic                          source_tvalid,
  input  logic                          source_tready,
  output logic                          source_tlast,
  output logic [TDATA_WIDTH-1:0]        source_tdata,
  output logic [KEEP_W-1:0]             source_tkeep,
  output logic [TUSER_WIDTH-1:0]        source_tuser_vendor,
  output logic [IDX_W-1:0]              grant_ch,
  output logic                          pkt_in_flight,
  output logic [NUM_CH-1:0]             err_hdr_only_multi
);

  t_merge_state state_reg, state_next;
  logic [NUM_CH-1:0]      grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   sel_valid, eff_last, stage_ready, accept, lock;
  logic [NUM_CH-1:0]      eff_last_vec;
  logic [TDATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [KEEP_W-1:0]      ch_keep [NUM_CH];
  logic [TUSER_WIDTH-1:0] ch_user [NUM_CH];
  logic [NUM_CH-1:0]      err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]      = sink_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
      assign ch_keep[gi]      = sink_tkeep[gi*KEEP_W +: KEEP_W];
      assign ch_user[gi]      = sink_tuser_vendor[gi*TUSER_WIDTH +: TUSER_WIDTH];
      assign eff_last_vec[gi] = sink_tlast[gi] | HDR_ONLY_MASK[gi];
    end
  endgenerate

  ofs_fim_pcie_ss_wrr_arb #(
    .NUM_CH   (NUM_CH),
    .WEIGHT_W (WEIGHT_W),
    .WEIGHTS  (WEIGHTS)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (sink_tvalid),
    .accept      (accept),
    .last        (eff_last),
    .lock        (lock),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .rr_ptr      (grant_ch)
  );

  assign lock        = (state_reg == LOCKED);
  assign sel_valid   = grant_valid & sink_tvalid[grant_idx];
  assign eff_last    = eff_last_vec[grant_idx];
  assign accept      = sel_valid & stage_ready;
  assign sink_tready = grant & {NUM_CH{stage_ready}};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB:     if (accept && !eff_last) state_next = LOCKED;
      LOCKED:  if (accept && eff_last)  state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_reg | (HDR_ONLY_MASK & sink_tvalid & ~sink_tlast);
    end
  end

  assign pkt_in_flight      = lock;
  assign err_hdr_only_multi = err_reg;

  generate
    if (REGISTER_OUTPUT != 0) begin : g_reg_out
      logic                   out_valid_reg, out_last_reg;
      logic [TDATA_WIDTH-1:0] out_data_reg;
      logic [KEEP_W-1:0]      out_keep_reg;
      logic [TUSER_WIDTH-1:0] out_user_reg;

      // Loading whenever empty or draining keeps one beat per cycle.
      assign stage_ready = source_tready | ~out_valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
          out_data_reg  <= '0;
          out_keep_reg  <= '0;
          out_user_reg  <= '0;
        end else if (stage_ready) begin
          out_valid_reg <= accept;
          if (accept) begin
            out_last_reg <= eff_last;
            out_data_reg <= ch_data[grant_idx];
            out_keep_reg <= ch_keep[grant_idx];
            out_user_reg <= ch_user[grant_idx];
          end
        end
      end

      assign source_tvalid       = out_valid_reg;
      assign source_tlast        = out_last_reg;
      assign source_tdata        = out_data_reg;
      assign source_tkeep        = out_keep_reg;
      assign source_tuser_vendor = out_user_reg;
    end else begin : g_comb_out
      assign stage_ready         = source_tready;
      assign source_tvalid       = sel_valid;
      assign source_tlast        = eff_last;
      assign source_tdata        = ch_data[grant_idx];
      assign source_tkeep        = ch_keep[grant_idx];
      assign source_tuser_vendor = ch_user[grant_idx];
    end
  endgenerate

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_merge_nch.sv
// Directed bench: instance A (weights 1, ch1 header-only, registered), B (weights {3,1,1}, comb).
module tb_ofs_fim_pcie_ss_tx_merge_nch;

  localparam int NC = 3;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam int NPKT = 30;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]    a_tvalid, a_tready, a_tlast, a_err;
  logic [NC*DW-1:0] a_tdata;
  logic [NC*KW-1:0] a_tkeep;
  logic [NC*UW-1:0] a_tuser;
  logic             a_o_tvalid, a_o_tready, a_o_tlast, a_pif;
  logic [DW-1:0]    a_o_tdata;
  logic [KW-1:0]    a_o_tkeep;
  logic [UW-1:0]    a_o_tuser;
  logic [1:0]       a_grant_ch;

  logic [NC-1:0]    b_tvalid, b_tready, b_tlast, b_err;
  logic [NC*DW-1:0] b_tdata;
  logic [NC*KW-1:0] b_tkeep;
  logic [NC*UW-1:0] b_tuser;
  logic             b_o_tvalid, b_o_tready, b_o_tlast, b_pif;
  logic [DW-1:0]    b_o_tdata;
  logic [KW-1:0]    b_o_tkeep;
  logic [UW-1:0]    b_o_tuser;
  logic [1:0]       b_grant_ch;

  ofs_fim_pcie_ss_tx_merge_nch #(
    .NUM_CH(NC), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .HDR_ONLY_MASK(3'b010),
    .WEIGHT_W(4), .WEIGHTS(12'h111), .REGISTER_OUTPUT(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .sink_tvalid(a_tvalid), .sink_tready(a_tready), .sink_tlast(a_tlast),
    .sink_tdata(a_tdata), .sink_tkeep(a_tkeep), .sink_tuser_vendor(a_tuser),
    .source_tvalid(a_o_tvalid), .source_tready(a_o_tready), .source_tlast(a_o_tlast),
    .source_tdata(a_o_tdata), .source_tkeep(a_o_tkeep), .source_tuser_vendor(a_o_tuser),
    .grant_ch(a_grant_ch), .pkt_in_flight(a_pif), .err_hdr_only_multi(a_err)
  );

  ofs_fim_pcie_ss_tx_merge_nch #(
    .NUM_CH(NC), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .HDR_ONLY_MASK(3'b000),
    .WEIGHT_W(4), .WEIGHTS(12'h311), .REGISTER_OUTPUT(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .sink_tvalid(b_tvalid), .sink_tready(b_tready), .sink_tlast(b_tlast),
    .sink_tdata(b_tdata), .sink_tkeep(b_tkeep), .sink_tuser_vendor(b_tuser),
    .source_tvalid(b_o_tvalid), .source_tready(b_o_tready), .source_tlast(b_o_tlast),
    .source_tdata(b_o_tdata), .source_tkeep(b_o_tkeep), .source_tuser_vendor(b_o_tuser),
    .grant_ch(b_grant_ch), .pkt_in_flight(b_pif), .err_hdr_only_multi(b_err)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_a(input int c, input logic v, input logic l, input logic [DW-1:0] d);
    a_tvalid[c] = v;
    a_tlast[c]  = l;
    a_tdata[c*DW +: DW] = d;
  endtask

  function automatic int pkt_len(input int c, input int p);
    if (c == 1) return 1;
    return ((p * 7 + c * 3) % 4) + 1;
  endfunction

  function automatic logic [31:0] mkword(input int c, input int p, input int b);
    return {c[3:0], p[11:0], b[7:0], 8'h5A};
  endfunction

  // Lock test tables, bit/element k = step k.
  logic [8:0]  t_c0v  = 9'b001100011;
  logic [8:0]  t_c0l  = 9'b001000000;
  logic [8:0]  t_rdy1 = 9'b010000000;
  logic [8:0]  t_ov   = 9'b111000110;
  logic [8:0]  t_pif  = 9'b001111110;
  int          t_c0b [9] = '{0, 1, 0, 0, 0, 2, 3, 0, 0};
  logic [31:0] t_od  [9] = '{32'h0, 32'hA00, 32'hA01, 32'h0, 32'h0, 32'h0,
                             32'hA02, 32'hA03, 32'h0100_0001};
  int          rot_a [6]  = '{0, 1, 2, 0, 1, 2};
  int          rot_b [10] = '{0, 1, 2, 2, 2, 0, 1, 2, 2, 2};

  int dpkt [NC], dbeat [NC], opkt [NC], obeat [NC];
  int total, recv, oc, owner;
  logic hold, hlast, in_pkt, exp_l;
  logic [DW-1:0] hdata, exp_w;
  logic [NC-1:0] acc;

  initial begin
    rst_n = 1'b0;
    a_tvalid = '0; a_tlast = '0; a_tdata = '0; a_tkeep = '1;
    a_tuser = {10'd2, 10'd1, 10'd0}; a_o_tready = 1'b1;
    b_tvalid = '0; b_tlast = '0; b_tdata = '0; b_tkeep = '1;
    b_tuser = '0; b_o_tready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_tvalid", a_o_tvalid, 0);
    chk("rst_a_grant_ch", a_grant_ch, 0);
    chk("rst_a_pif", a_pif, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_tvalid", b_o_tvalid, 0);
    rst_n = 1'b1;

    // Equal weights, all valid, 1-beat packets: strict rotation, no bubbles
    a_tvalid = 3'b111; a_tlast = 3'b111; a_tdata = {32'd2, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rot_a_tvalid", a_o_tvalid, 1);
      chk("rot_a_tdata", a_o_tdata, rot_a[i]);
      $display("rot_a beat %0d ch=%0d", i, a_o_tdata);
    end
    chk("rot_a_grant_ch", a_grant_ch, 2);
    a_tvalid = '0; a_tlast = '0;
    repeat (2) @(posedge clk);
    #1;

    // Weights {3,1,1}, combinational output: 0,1,2,2,2 repeating
    b_tvalid = 3'b111; b_tlast = 3'b111; b_tdata = {32'd2, 32'd1, 32'd0};
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("wrr_b_tvalid", b_o_tvalid, 1);
      chk("wrr_b_tdata", b_o_tdata, rot_b[i]);
      $display("wrr_b beat %0d ch=%0d", i, b_o_tdata);
      @(posedge clk); #1;
    end
    b_tvalid = '0;

    // Ch0 4-beat packet stalls 3 cycles while ch1 waits: bubbles, lock held
    for (int k = 0; k < 9; k++) begin
      if (t_c0v[k]) drive_a(0, 1'b1, t_c0l[k], 32'hA00 + t_c0b[k]);
      else drive_a(0, 1'b0, 1'b0, 32'h0);
      if (k < 8) drive_a(1, 1'b1, 1'b1, 32'h0100_0001);
      else drive_a(1, 1'b0, 1'b0, 32'h0);
      #1;
      chk("lock_rdy1", a_tready[1], t_rdy1[k]);
      chk("lock_ovalid", a_o_tvalid, t_ov[k]);
      if (t_ov[k]) chk("lock_odata", a_o_tdata, t_od[k]);
      chk("lock_pif", a_pif, t_pif[k]);
      $display("lock step %0d ovalid=%0d odata=%0h", k, a_o_tvalid, a_o_tdata);
      @(posedge clk); #1;
    end

    // Header-only ch1 with tlast=0: forced tlast, sticky error, no lock
    a_tkeep[KW +: KW] = 4'b0101;
    a_tuser[UW +: UW] = 10'h2A5;
    drive_a(1, 1'b1, 1'b0, 32'h11);
    #1;
    chk("ho_ready", a_tready, 3'b010);
    @(posedge clk); #1;
    drive_a(1, 1'b0, 1'b0, 32'h0);
    chk("ho_tvalid", a_o_tvalid, 1);
    chk("ho_tlast", a_o_tlast, 1);
    chk("ho_tdata", a_o_tdata, 32'h11);
    chk("ho_tkeep", a_o_tkeep, 4'b0101);
    chk("ho_tuser", a_o_tuser, 10'h2A5);
    chk("ho_err", a_err, 3'b010);
    chk("ho_pif", a_pif, 0);
    $display("ho beat tlast=%0d err=%b", a_o_tlast, a_err);
    @(posedge clk); #1;
    chk("ho_err_sticky", a_err, 3'b010);
    chk("ho_pif_idle", a_pif, 0);
    chk("ho_tvalid_idle", a_o_tvalid, 0);
    a_tkeep = '1;
    a_tuser = {10'd2, 10'd1, 10'd0};

    // Mixed-length packets, random valid and 50% backpressure, scoreboarded
    total = 0;
    for (int c = 0; c < NC; c++) begin
      dpkt[c] = 0; dbeat[c] = 0; opkt[c] = 0; obeat[c] = 0;
      for (int p = 0; p < NPKT; p++) total += pkt_len(c, p);
    end
    recv = 0; hold = 1'b0; in_pkt = 1'b0; owner = 0;
    for (int cyc = 0; cyc < 5000 && recv < total; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (dpkt[c] < NPKT)
          drive_a(c, ($urandom_range(0, 3) != 0), (dbeat[c] == pkt_len(c, dpkt[c]) - 1),
                  mkword(c, dpkt[c], dbeat[c]));
        else
          drive_a(c, 1'b0, 1'b0, 32'h0);
      end
      a_o_tready = ($urandom_range(0, 1) == 1);
      #1;
      if (hold) begin
        chk("bp_hold_valid", a_o_tvalid, 1);
        chk("bp_hold_beat", {a_o_tlast, a_o_tdata}, {hlast, hdata});
      end
      acc = a_tvalid & a_tready;
      if (a_o_tvalid && a_o_tready) begin
        oc = int'(a_o_tdata[31:28]);
        if (oc >= NC) begin
          chk("sb_chan", oc, 0);
        end else begin
          exp_w = mkword(oc, opkt[oc], obeat[oc]);
          exp_l = (obeat[oc] == pkt_len(oc, opkt[oc]) - 1);
          chk("sb_beat", {a_o_tlast, a_o_tdata}, {exp_l, exp_w});
          if (in_pkt) chk("sb_no_interleave", oc, owner);
          in_pkt = !a_o_tlast;
          owner  = oc;
          if (exp_l) begin
            $display("sb pkt ch=%0d num=%0d len=%0d", oc, opkt[oc], pkt_len(oc, opkt[oc]));
            opkt[oc]++;
            obeat[oc] = 0;
          end else begin
            obeat[oc]++;
          end
        end
        recv++;
      end
      hold  = a_o_tvalid && !a_o_tready;
      hdata = a_o_tdata;
      hlast = a_o_tlast;
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) begin
        if (acc[c]) begin
          if (dbeat[c] == pkt_len(c, dpkt[c]) - 1) begin
            dpkt[c]++;
            dbeat[c] = 0;
          end else begin
            dbeat[c]++;
          end
        end
      end
    end
    chk("sb_complete", recv, total);
    a_tvalid = '0; a_tlast = '0; a_o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-packet on locked ch2
    drive_a(2, 1'b1, 1'b0, 32'hC200_0000);
    @(posedge clk); #1;
    drive_a(2, 1'b1, 1'b0, 32'hC200_0001);
    chk("mid_pif", a_pif, 1);
    chk("mid_grant_ch", a_grant_ch, 2);
    chk("mid_tvalid", a_o_tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", a_o_tvalid, 0);
    chk("arst_pif", a_pif, 0);
    chk("arst_grant_ch", a_grant_ch, 0);
    drive_a(2, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_a(1, 1'b1, 1'b1, 32'hC100_0000);
    #1;
    chk("post_rst_ready", a_tready, 3'b010);
    @(posedge clk); #1;
    drive_a(1, 1'b0, 1'b0, 32'h0);
    chk("post_rst_tvalid", a_o_tvalid, 1);
    chk("post_rst_tdata", a_o_tdata, 32'hC100_0000);
    chk("post_rst_pif", a_pif, 0);
    $display("post reset beat %0h", a_o_tdata);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
